// File: rtl/keycode_report_encoder_if.sv
// Event/report bus of the keycode report encoder: key events in, 6-slot HID report out.
interface keycode_report_encoder_if;
  logic        evt_valid;
  logic        evt_ready;
  logic [7:0]  evt_code;
  logic        evt_press;
  logic        clear;
  logic [47:0] keycodes;
  logic        report_valid;
  logic        rollover;
  logic [2:0]  key_count;

  modport master (
    output evt_valid, evt_code, evt_press, clear,
    input  evt_ready, keycodes, report_valid, rollover, key_count
  );

  modport slave (
    input  evt_valid, evt_code, evt_press, clear,
    output evt_ready, keycodes, report_valid, rollover, key_count
  );
endinterface

// File: rtl/keycode_report_encoder.sv
// Turns press/release key events into a compacted 6-slot HID keycode report with
// rollover signalling; one event in flight at a time (IDLE -> MATCH -> [SHIFT] -> COMMIT).
module keycode_report_encoder #(
  parameter int         NUM_SLOTS     = 6,
  parameter logic [7:0] ROLLOVER_CODE = 8'h01
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  keycode_report_encoder_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_MATCH, S_SHIFT, S_COMMIT} state_t;

  localparam logic [2:0] LP_FULL = 3'(NUM_SLOTS);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_slot [NUM_SLOTS];
  logic [2:0]  r_count;
  logic [2:0]  r_ptr;
  logic        r_rollover;
  logic [7:0]  r_code;
  logic        r_press;
  logic [47:0] r_keycodes;
  logic [2:0]  r_key_count;
  logic        r_rollover_out;
  logic        r_report_valid;

  logic        w_ready;
  logic        w_accept;
  logic        w_ignore;
  logic        w_hit;
  logic [2:0]  w_hit_idx;
  logic [47:0] w_slots_flat;
  logic [47:0] w_pub_keys;
  logic [2:0]  w_pub_count;
  logic        w_pub_roll;
  logic        w_changed;

  assign w_ready  = (r_state == S_IDLE) && !bus.clear && Reset_n;
  assign w_accept = bus.evt_valid && w_ready;
  assign w_ignore = (r_code < 8'h04);

  // Parallel lookup of the latched code; codes are unique so OR-ing indices is safe.
  always_comb begin
    w_hit        = 1'b0;
    w_hit_idx    = 3'd0;
    w_slots_flat = 48'd0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_hit                  = w_hit | ((3'(i) < r_count) && (r_slot[i] == r_code));
      w_hit_idx              = w_hit_idx | (((3'(i) < r_count) && (r_slot[i] == r_code)) ? 3'(i) : 3'd0);
      w_slots_flat[8*i +: 8] = r_slot[i];
    end
  end

  // Clear publishes zeros directly so a held clear yields a single report.
  always_comb begin
    w_pub_keys  = bus.clear ? 48'd0 : (r_rollover ? {NUM_SLOTS{ROLLOVER_CODE}} : w_slots_flat);
    w_pub_count = bus.clear ? 3'd0 : r_count;
    w_pub_roll  = bus.clear ? 1'b0 : r_rollover;
    w_changed   = (w_pub_keys != r_keycodes) || (w_pub_count != r_key_count) || (w_pub_roll != r_rollover_out);
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.clear) begin
      w_state_nxt = S_COMMIT;
    end else begin
      case (r_state)
        S_IDLE:   w_state_nxt = w_accept ? S_MATCH : S_IDLE;
        S_MATCH:  w_state_nxt = (!w_ignore && !r_press && w_hit) ? S_SHIFT : S_COMMIT;
        S_SHIFT:  w_state_nxt = (r_ptr == (r_count - 3'd1)) ? S_COMMIT : S_SHIFT;
        S_COMMIT: w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from state.
  always_comb begin
    bus.evt_ready = w_ready;
  end

  // Slot table, event latch and compaction pointer.
  always_ff @(posedge Clk) begin
    if (!Reset_n || bus.clear) begin
      for (int i = 0; i < NUM_SLOTS; i++) r_slot[i] <= 8'h00;
      r_count    <= 3'd0;
      r_ptr      <= 3'd0;
      r_rollover <= 1'b0;
      r_code     <= (!Reset_n) ? 8'h00 : r_code;
      r_press    <= (!Reset_n) ? 1'b0 : r_press;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_code  <= bus.evt_code;
            r_press <= bus.evt_press;
          end else begin
            r_code  <= r_code;
          end
        end
        S_MATCH: begin
          if (w_ignore) begin
            r_ptr <= r_ptr;
          end else if (r_press) begin
            if (w_hit) begin
              r_ptr <= r_ptr;
            end else if (r_count < LP_FULL) begin
              r_slot[r_count] <= r_code;
              r_count         <= r_count + 3'd1;
            end else begin
              r_rollover <= 1'b1;
            end
          end else begin
            r_rollover <= 1'b0;
            r_ptr      <= w_hit ? w_hit_idx : r_ptr;
          end
        end
        S_SHIFT: begin
          if (r_ptr < (r_count - 3'd1)) begin
            r_slot[r_ptr] <= r_slot[r_ptr + 3'd1];
            r_ptr         <= r_ptr + 3'd1;
          end else begin
            r_slot[r_ptr] <= 8'h00;
            r_count       <= r_count - 3'd1;
          end
        end
        default: r_ptr <= r_ptr;
      endcase
    end
  end

  // Published report; report_valid is guarded against back-to-back pulses.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_keycodes     <= 48'd0;
      r_key_count    <= 3'd0;
      r_rollover_out <= 1'b0;
      r_report_valid <= 1'b0;
    end else if (r_state == S_COMMIT) begin
      r_keycodes     <= w_pub_keys;
      r_key_count    <= w_pub_count;
      r_rollover_out <= w_pub_roll;
      r_report_valid <= w_changed && !r_report_valid;
    end else begin
      r_report_valid <= 1'b0;
    end
  end

  assign bus.keycodes     = r_keycodes;
  assign bus.key_count    = r_key_count;
  assign bus.rollover     = r_rollover_out;
  assign bus.report_valid = r_report_valid;
endmodule

// File: tb/tb_keycode_report_encoder.sv
// Directed bench: stimulus pushes expected reports into a scoreboard queue,
// a negedge monitor pops one per report_valid pulse and compares.
module tb_keycode_report_encoder;
  typedef struct packed {
    logic [47:0] keys;
    logic [2:0]  cnt;
    logic        roll;
  } rep_t;

  logic clk = 1'b0;
  logic Reset_n;
  int   n_vec = 0;
  int   n_err = 0;
  logic prev_rv = 1'b0;
  rep_t sb[$];

  keycode_report_encoder_if bus ();

  keycode_report_encoder dut (
    .Clk     (clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_rep(input logic [47:0] k, input logic [2:0] c, input logic r);
    sb.push_back({k, c, r});
  endtask

  // Monitor: every report pulse must match the oldest expected report.
  always @(negedge clk) begin
    if (bus.report_valid) begin
      check("no_back_to_back", {63'd0, prev_rv}, 64'd0);
      if (sb.size() == 0) begin
        check("unexpected_report", 64'd1, 64'd0);
      end else begin
        check("report", {12'd0, bus.keycodes, bus.key_count, bus.rollover}, {12'd0, sb.pop_front()});
      end
    end
    prev_rv <= bus.report_valid;
  end

  task automatic accept_only(input logic [7:0] code, input logic press);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.evt_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 64'd1, 64'd0);
    bus.evt_code  = code;
    bus.evt_press = press;
    bus.evt_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.evt_valid = 1'b0;
  endtask

  task automatic send(input string name, input logic [7:0] code, input logic press, input int exp_lat);
    int lat;
    accept_only(code, press);
    lat = 0;
    while (lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.evt_ready) break;
    end
    check(name, 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    Reset_n       = 1'b0;
    bus.evt_valid = 1'b0;
    bus.evt_code  = 8'h00;
    bus.evt_press = 1'b0;
    bus.clear     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_keycodes", {16'd0, bus.keycodes}, 64'd0);
    check("rst_count", {61'd0, bus.key_count}, 64'd0);
    check("rst_flags", {61'd0, bus.rollover, bus.report_valid, bus.evt_ready}, 64'd0);
    Reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {63'd0, bus.evt_ready}, 64'd1);

    // Basic press and release with compaction
    expect_rep(48'h0000_0000_0004, 3'd1, 1'b0); send("lat_press_04", 8'h04, 1'b1, 2);
    expect_rep(48'h0000_0000_0704, 3'd2, 1'b0); send("lat_press_07", 8'h07, 1'b1, 2);
    expect_rep(48'h0000_001A_0704, 3'd3, 1'b0); send("lat_press_1A", 8'h1A, 1'b1, 2);
    expect_rep(48'h0000_0000_1A07, 3'd2, 1'b0); send("lat_release_j0", 8'h04, 1'b0, 5);

    // Duplicate press, absent release: no reports
    send("lat_dup_press", 8'h07, 1'b1, 2);
    check("dup_count", {61'd0, bus.key_count}, 64'd2);
    expect_rep(48'h0000_0005_1A07, 3'd3, 1'b0); send("lat_press_05", 8'h05, 1'b1, 2);
    send("lat_absent_rel", 8'h2C, 1'b0, 2);
    check("absent_keys", {16'd0, bus.keycodes}, 64'h0000_0000_0005_1A07);

    // Clear held for three edges: exactly one report
    expect_rep(48'h0, 3'd0, 1'b0);
    @(negedge clk); bus.clear = 1'b1;
    repeat (3) @(posedge clk);
    #1; bus.clear = 1'b0;
    repeat (4) @(negedge clk);
    check("clear_keys", {16'd0, bus.keycodes}, 64'd0);

    // Fill to rollover
    expect_rep(48'h0000_0000_0004, 3'd1, 1'b0); send("lat_p04", 8'h04, 1'b1, 2);
    expect_rep(48'h0000_0000_0504, 3'd2, 1'b0); send("lat_p05", 8'h05, 1'b1, 2);
    expect_rep(48'h0000_0006_0504, 3'd3, 1'b0); send("lat_p06", 8'h06, 1'b1, 2);
    expect_rep(48'h0000_0706_0504, 3'd4, 1'b0); send("lat_p07", 8'h07, 1'b1, 2);
    expect_rep(48'h0008_0706_0504, 3'd5, 1'b0); send("lat_p08", 8'h08, 1'b1, 2);
    expect_rep(48'h0908_0706_0504, 3'd6, 1'b0); send("lat_p09", 8'h09, 1'b1, 2);
    expect_rep(48'h0101_0101_0101, 3'd6, 1'b1); send("lat_p0A_roll", 8'h0A, 1'b1, 2);
    send("lat_ignored_02", 8'h02, 1'b1, 2);
    check("roll_flag", {63'd0, bus.rollover}, 64'd1);
    expect_rep(48'h0009_0807_0605, 3'd5, 1'b0); send("lat_rel04_roll", 8'h04, 1'b0, 8);
    expect_rep(48'h0000_0807_0605, 3'd4, 1'b0); send("lat_rel_last", 8'h09, 1'b0, 3);

    // Clear during SHIFT of a release
    expect_rep(48'h0, 3'd0, 1'b0);
    accept_only(8'h05, 1'b0);
    @(posedge clk); #1; bus.clear = 1'b1;
    @(posedge clk); #1; bus.clear = 1'b0;
    repeat (5) @(negedge clk);
    check("clr_shift_keys", {16'd0, bus.keycodes}, 64'd0);
    check("clr_shift_cnt", {61'd0, bus.key_count}, 64'd0);

    // Reset mid-SHIFT
    expect_rep(48'h0000_0000_0004, 3'd1, 1'b0); send("lat_r04", 8'h04, 1'b1, 2);
    expect_rep(48'h0000_0000_0504, 3'd2, 1'b0); send("lat_r05", 8'h05, 1'b1, 2);
    expect_rep(48'h0000_0006_0504, 3'd3, 1'b0); send("lat_r06", 8'h06, 1'b1, 2);
    accept_only(8'h04, 1'b0);
    @(posedge clk); #1; Reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_keys", {16'd0, bus.keycodes}, 64'd0);
    check("rst_mid_flags", {58'd0, bus.key_count, bus.rollover, bus.report_valid, bus.evt_ready}, 64'd0);
    Reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_mid_stays0", {16'd0, bus.keycodes}, 64'd0);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
